// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared types and constants.
// Also used by the receive-side decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  typedef logic [1:0] ps2_err_t;

  localparam ps2_err_t ERR_NONE    = 2'b00;
  localparam ps2_err_t ERR_TIMEOUT = 2'b01;
  localparam ps2_err_t ERR_NOACK   = 2'b10;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the
// PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  ps2_err_t   err_code;
  logic       busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, tx_error,
    input  err_code, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, tx_error,
    output err_code, busy
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises and debounces one PS/2 line and
// flags the filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(FILTER_LEN - 1);

  logic [1:0]    sync_ff;
  logic [CW-1:0] cnt;

  // two-flop synchroniser, idles high like the bus
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_ff <= 2'b11;
    else          sync_ff <= {sync_ff[0], line};
  end

  // level flips after FILTER_LEN disagreeing samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_ff[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_ff[1];
        cnt   <= '0;
        fall  <= ~sync_ff[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving
// open-collector pull-down enables on both lines.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clock_i,
  input  logic          ps2_data_i,
  output logic          ps2_clock_oe,
  output logic          ps2_data_oe
);

  localparam int CNT_MAX =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INH_LAST =
    CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_PRE =
    CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
  localparam logic INH_ONE = (INHIBIT_CYCLES == 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [8:0]    shreg;
  logic [3:0]    nbits;

  logic clk_lvl;
  logic clk_fall;
  logic dat_lvl;
  logic data_fall_unused;
  logic accept;
  logic timed;
  logic timeout;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filt (
    .clock   (clock),
    .reset_n (reset_n),
    .line    (ps2_clock_i),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filt (
    .clock   (clock),
    .reset_n (reset_n),
    .line    (ps2_data_i),
    .level   (dat_lvl),
    .fall    (data_fall_unused)
  );

  assign bus.tx_ready = (state == IDLE) && clk_lvl;
  assign bus.busy     = (state != IDLE);
  assign accept       = bus.tx_valid && bus.tx_ready;

  assign timed   = state inside {REQ, DATA, ACK, WAIT_IDLE};
  assign timeout = timed && (cnt == TO_LAST);
  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

  // sequencer: inhibit, request, shift bits, ack, bus idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      nbits        <= '0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      bus.tx_done  <= 1'b0;
      bus.tx_error <= 1'b0;
      bus.err_code <= ERR_NONE;
    end else begin
      bus.tx_done  <= 1'b0;
      bus.tx_error <= 1'b0;
      if (timeout) begin
        state        <= IDLE;
        ps2_clock_oe <= 1'b0;
        ps2_data_oe  <= 1'b0;
        bus.tx_error <= 1'b1;
        bus.err_code <= ERR_TIMEOUT;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              state        <= INHIBIT;
              cnt          <= '0;
              shreg        <= {odd_parity(bus.tx_data),
                               bus.tx_data};
              ps2_clock_oe <= 1'b1;
              ps2_data_oe  <= INH_ONE;
            end
          end
          INHIBIT: begin
            if (cnt == INH_LAST) begin
              state        <= REQ;
              cnt          <= '0;
              ps2_clock_oe <= 1'b0;
              ps2_data_oe  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
              if (cnt == INH_PRE) ps2_data_oe <= 1'b1;
            end
          end
          REQ: begin
            cnt <= cnt_inc;
            if (clk_fall) begin
              state       <= DATA;
              nbits       <= 4'd1;
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[8:1]};
            end
          end
          DATA: begin
            cnt <= cnt_inc;
            if (clk_fall) begin
              if (nbits == 4'd9) begin
                state       <= ACK;
                ps2_data_oe <= 1'b0;
              end else begin
                nbits       <= nbits + 4'd1;
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[8:1]};
              end
            end
          end
          ACK: begin
            cnt <= cnt_inc;
            if (clk_fall) begin
              if (!dat_lvl) begin
                state <= WAIT_IDLE;
              end else begin
                state        <= IDLE;
                ps2_clock_oe <= 1'b0;
                ps2_data_oe  <= 1'b0;
                bus.tx_error <= 1'b1;
                bus.err_code <= ERR_NOACK;
              end
            end
          end
          WAIT_IDLE: begin
            cnt <= cnt_inc;
            if (clk_lvl && dat_lvl) begin
              state       <= IDLE;
              bus.tx_done <= 1'b1;
            end
          end
          default: begin
            state        <= IDLE;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
